// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: RAW forwarding / load-use stall for decode, plus
// execute-stage branch resolution with a registered PC redirect and a
// multi-cycle flush of fetch/decode.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   de_rs1/2, de_rs1/2_used     decode source indices and use flags
//   de_rf_a/b                   register-file read data
//   stg_rd/wen/rdy/data         per-stage producer info, stage 0 = youngest
//   exe_is_br/is_jmp/funct3     execute-stage control transfer
//   exe_a/b, exe_target         branch operands and target
//   fwd_a/b, fwd_sel_a/b        resolved operands (combinational)
//   stall                       load-use stall (combinational)
//   pc_sel, pc_target           one-cycle registered redirect
//   flush                       squash fetch/decode, FLUSH_CYCLES long
//   stall_cnt, flush_cnt        perf counters, built only when
//                               HAZARD_PERF_CNT_EN is defined
module hazard_ctrl_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FWD_STAGES   = 3,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 de_rs1,
    input  logic [4:0]                 de_rs2,
    input  logic                       de_rs1_used,
    input  logic                       de_rs2_used,
    input  logic [XLEN-1:0]            de_rf_a,
    input  logic [XLEN-1:0]            de_rf_b,
    input  logic [5*FWD_STAGES-1:0]    stg_rd,
    input  logic [FWD_STAGES-1:0]      stg_wen,
    input  logic [FWD_STAGES-1:0]      stg_rdy,
    input  logic [XLEN*FWD_STAGES-1:0] stg_data,
    input  logic                       exe_is_br,
    input  logic                       exe_is_jmp,
    input  logic [2:0]                 exe_funct3,
    input  logic [XLEN-1:0]            exe_a,
    input  logic [XLEN-1:0]            exe_b,
    input  logic [XLEN-1:0]            exe_target,
    output logic [XLEN-1:0]            fwd_a,
    output logic [XLEN-1:0]            fwd_b,
    output logic                       fwd_sel_a,
    output logic                       fwd_sel_b,
    output logic                       stall,
    output logic                       pc_sel,
    output logic [XLEN-1:0]            pc_target,
    output logic                       flush,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
);

    localparam int unsigned RW    = 5;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pc_sel_q, pc_sel_d;
    logic [XLEN-1:0]    pc_target_q, pc_target_d;

    logic               rdy_a, rdy_b;
    logic               br_cond;
    logic               taken;

    // Operand forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a     = de_rf_a;
        fwd_b     = de_rf_b;
        fwd_sel_a = 1'b0;
        fwd_sel_b = 1'b0;
        rdy_a     = 1'b1;
        rdy_b     = 1'b1;
        for (int i = int'(FWD_STAGES) - 1; i >= 0; i--) begin
            if (de_rs1_used && (de_rs1 != 5'd0) && stg_wen[i] &&
                (stg_rd[RW*i +: RW] == de_rs1)) begin
                fwd_a     = stg_data[XLEN*i +: XLEN];
                fwd_sel_a = 1'b1;
                rdy_a     = stg_rdy[i];
            end
            if (de_rs2_used && (de_rs2 != 5'd0) && stg_wen[i] &&
                (stg_rd[RW*i +: RW] == de_rs2)) begin
                fwd_b     = stg_data[XLEN*i +: XLEN];
                fwd_sel_b = 1'b1;
                rdy_b     = stg_rdy[i];
            end
        end
    end

    // Load-use stall; meaningless while squashing, so masked by flush.
    assign stall = ((fwd_sel_a & ~rdy_a) | (fwd_sel_b & ~rdy_b)) & ~flush;

    // Branch condition evaluation.
    always_comb begin
        br_cond = 1'b0;
        case (exe_funct3)
            3'b000:  br_cond = (exe_a == exe_b);
            3'b001:  br_cond = (exe_a != exe_b);
            3'b100:  br_cond = ($signed(exe_a) <  $signed(exe_b));
            3'b101:  br_cond = ($signed(exe_a) >= $signed(exe_b));
            3'b110:  br_cond = (exe_a <  exe_b);
            3'b111:  br_cond = (exe_a >= exe_b);
            default: br_cond = 1'b0;
        endcase
    end

    // Wrong-path transfers seen during flush are ignored.
    assign taken = ~flush & (exe_is_jmp | (exe_is_br & br_cond));

    // Redirect/flush FSM: next state and registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_sel_d    = 1'b0;
        pc_target_d = pc_target_q;
        case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d     = FLUSH;
                    cnt_d       = CNT_W'(FLUSH_CYCLES);
                    pc_sel_d    = 1'b1;
                    pc_target_d = exe_target;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_sel_q    <= 1'b0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_sel_q    <= pc_sel_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign pc_sel    = pc_sel_q;
    assign pc_target = pc_target_q;
    assign flush     = (state_q == FLUSH);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (pc_sel_q && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit: directed test-plan cases plus randomized
// traffic checked against a cycle-level reference model.
module tb_hazard_ctrl_unit;

    localparam int XLEN = 32;
    localparam int NS   = 3;
    localparam int FC   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        de_rs1, de_rs2;
    logic              de_rs1_used, de_rs2_used;
    logic [XLEN-1:0]   de_rf_a, de_rf_b;
    logic [5*NS-1:0]   stg_rd;
    logic [NS-1:0]     stg_wen, stg_rdy;
    logic [XLEN*NS-1:0] stg_data;
    logic              exe_is_br, exe_is_jmp;
    logic [2:0]        exe_funct3;
    logic [XLEN-1:0]   exe_a, exe_b, exe_target;
    logic [XLEN-1:0]   fwd_a, fwd_b;
    logic              fwd_sel_a, fwd_sel_b, stall, pc_sel, flush;
    logic [XLEN-1:0]   pc_target;
    logic [31:0]       stall_cnt, flush_cnt;

    // per-stage stimulus, packed onto the DUT buses below
    logic [4:0]        t_rd   [NS];
    logic              t_wen  [NS];
    logic              t_rdy  [NS];
    logic [XLEN-1:0]   t_data [NS];

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            stg_rd[5*i +: 5]       = t_rd[i];
            stg_wen[i]             = t_wen[i];
            stg_rdy[i]             = t_rdy[i];
            stg_data[XLEN*i +: XLEN] = t_data[i];
        end
    end

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.XLEN(XLEN), .FWD_STAGES(NS), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .de_rf_a(de_rf_a), .de_rf_b(de_rf_b),
        .stg_rd(stg_rd), .stg_wen(stg_wen), .stg_rdy(stg_rdy), .stg_data(stg_data),
        .exe_is_br(exe_is_br), .exe_is_jmp(exe_is_jmp), .exe_funct3(exe_funct3),
        .exe_a(exe_a), .exe_b(exe_b), .exe_target(exe_target),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall(stall), .pc_sel(pc_sel), .pc_target(pc_target), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic            m_pc_sel;
    logic [XLEN-1:0] m_pc_target;
    int              m_flush_left;
    longint          m_stall_cnt, m_flush_cnt;
    int              pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // first (youngest) stage whose write matches rs, -1 for none
    function automatic int match_stage(input logic used, input logic [4:0] rs);
        for (int i = 0; i < NS; i++)
            if (used && rs != 5'd0 && t_wen[i] && t_rd[i] == rs) return i;
        return -1;
    endfunction

    function automatic logic branch_taken();
        longint sa, sb, ua, ub;
        sa = longint'($signed(exe_a));
        sb = longint'($signed(exe_b));
        ua = longint'({32'd0, exe_a});
        ub = longint'({32'd0, exe_b});
        if (exe_is_jmp) return 1'b1;
        if (!exe_is_br) return 1'b0;
        case (exe_funct3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa <  sb;
            3'd5: return sa >= sb;
            3'd6: return ua <  ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_stall();
        int sa, sb;
        logic lu;
        sa = match_stage(de_rs1_used, de_rs1);
        sb = match_stage(de_rs2_used, de_rs2);
        lu = (sa >= 0 && !t_rdy[sa]) || (sb >= 0 && !t_rdy[sb]);
        return lu && (m_flush_left == 0);
    endfunction

    task automatic model_reset();
        m_pc_sel     = 1'b0;
        m_pc_target  = '0;
        m_flush_left = 0;
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
    endtask

    task automatic check_all();
        int sa, sb;
        sa = match_stage(de_rs1_used, de_rs1);
        sb = match_stage(de_rs2_used, de_rs2);
        check("fwd_sel_a", 32'(fwd_sel_a), 32'(sa >= 0));
        check("fwd_sel_b", 32'(fwd_sel_b), 32'(sb >= 0));
        if (sa < 0)            check("fwd_a_rf", fwd_a, de_rf_a);
        else if (t_rdy[sa])    check("fwd_a", fwd_a, t_data[sa]);
        if (sb < 0)            check("fwd_b_rf", fwd_b, de_rf_b);
        else if (t_rdy[sb])    check("fwd_b", fwd_b, t_data[sb]);
        check("stall", 32'(stall), 32'(model_stall()));
        check("pc_sel", 32'(pc_sel), 32'(m_pc_sel));
        if (m_pc_sel) check("pc_target", pc_target, m_pc_target);
        check("flush", 32'(flush), 32'(m_flush_left > 0));
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'(m_stall_cnt));
        check("flush_cnt", flush_cnt, 32'(m_flush_cnt));
`else
        check("stall_cnt", stall_cnt, 32'd0);
        check("flush_cnt", flush_cnt, 32'd0);
`endif
        if (pc_sel) pulses++;
    endtask

    // check at negedge, advance model across the posedge, return at posedge+1
    task automatic cycle();
        logic tk, st;
        @(negedge clk);
        check_all();
        tk = (m_flush_left == 0) && branch_taken();
        st = model_stall();
        @(posedge clk);
        if (st && m_stall_cnt < 64'hFFFFFFFF) m_stall_cnt++;
        if (m_pc_sel && m_flush_cnt < 64'hFFFFFFFF) m_flush_cnt++;
        if (m_flush_left > 0) m_flush_left--;
        if (tk) begin
            m_pc_target  = exe_target;
            m_flush_left = FC;
        end
        m_pc_sel = tk;
        #1;
    endtask

    task automatic idle_inputs();
        de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
        de_rf_a = 32'hA0A0_0001; de_rf_b = 32'hB0B0_0002;
        for (int i = 0; i < NS; i++) begin
            t_rd[i] = 0; t_wen[i] = 0; t_rdy[i] = 1; t_data[i] = 0;
        end
        exe_is_br = 0; exe_is_jmp = 0; exe_funct3 = 0;
        exe_a = 0; exe_b = 0; exe_target = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_pc_sel", 32'(pc_sel), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_pc_target", pc_target, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        cycle();

        // youngest stage wins forwarding
        de_rs1 = 5; de_rs1_used = 1;
        t_rd[0] = 5; t_wen[0] = 1; t_rdy[0] = 1; t_data[0] = 32'h11;
        t_rd[2] = 5; t_wen[2] = 1; t_rdy[2] = 1; t_data[2] = 32'h22;
        #1;
        check("tp_fwd_a_young", fwd_a, 32'h11);
        check("tp_fwd_sel_a", 32'(fwd_sel_a), 32'd1);
        check("tp_no_stall", 32'(stall), 32'd0);
        cycle();

        // x0 never forwarded
        idle_inputs();
        de_rs2 = 0; de_rs2_used = 1;
        t_rd[0] = 0; t_wen[0] = 1; t_data[0] = 32'hDEAD;
        #1;
        check("tp_x0_fwd_b", fwd_b, de_rf_b);
        check("tp_x0_sel_b", 32'(fwd_sel_b), 32'd0);
        cycle();

        // load-use stall then resolution
        idle_inputs();
        de_rs1 = 7; de_rs1_used = 1;
        t_rd[0] = 7; t_wen[0] = 1; t_rdy[0] = 0;
        #1;
        check("tp_load_stall", 32'(stall), 32'd1);
        cycle();
        t_wen[0] = 0; t_rdy[0] = 1;
        t_rd[1] = 7; t_wen[1] = 1; t_rdy[1] = 1; t_data[1] = 32'h55;
        #1;
        check("tp_load_nostall", 32'(stall), 32'd0);
        check("tp_load_fwd", fwd_a, 32'h55);
        cycle();

        // BLT taken: redirect next cycle, flush for FC cycles
        idle_inputs();
        exe_is_br = 1; exe_funct3 = 3'b100;
        exe_a = 32'hFFFF_FFFF; exe_b = 32'd1; exe_target = 32'h100;
        cycle();
        idle_inputs();
        #1;
        check("tp_blt_pc_sel", 32'(pc_sel), 32'd1);
        check("tp_blt_target", pc_target, 32'h100);
        check("tp_blt_flush1", 32'(flush), 32'd1);
        cycle();
        check("tp_blt_flush2", 32'(flush), 32'd1);
        check("tp_blt_pulse", 32'(pc_sel), 32'd0);
        cycle();
        check("tp_blt_flush_end", 32'(flush), 32'd0);
        // BLTU same operands: not taken
        exe_is_br = 1; exe_funct3 = 3'b110;
        exe_a = 32'hFFFF_FFFF; exe_b = 32'd1; exe_target = 32'h200;
        cycle();
        idle_inputs();
        check("tp_bltu_no_redirect", 32'(pc_sel), 32'd0);
        cycle();

        // reset one cycle into flush
        exe_is_jmp = 1; exe_target = 32'h300;
        cycle();
        idle_inputs();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("tp_midrst_flush", 32'(flush), 32'd0);
        check("tp_midrst_pc_sel", 32'(pc_sel), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        check("tp_midrst_idle", 32'(flush), 32'd0);

        // JAL then taken BEQ during flush: one pulse only
        pulses = 0;
        exe_is_jmp = 1; exe_target = 32'h400;
        cycle();
        idle_inputs();
        exe_is_br = 1; exe_funct3 = 3'b000; exe_a = 32'd9; exe_b = 32'd9; exe_target = 32'h500;
        cycle();
        idle_inputs();
        for (int k = 0; k < 4; k++) cycle();
        check("tp_jal_beq_pulses", 32'(pulses), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        check("tp_jal_flush_cnt", flush_cnt, 32'd1);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            de_rs1 = 5'($urandom_range(0, 3));
            de_rs2 = 5'($urandom_range(0, 3));
            de_rs1_used = ($urandom_range(0, 7) != 0);
            de_rs2_used = ($urandom_range(0, 7) != 0);
            de_rf_a = $urandom;
            de_rf_b = $urandom;
            for (int i = 0; i < NS; i++) begin
                t_rd[i]   = 5'($urandom_range(0, 3));
                t_wen[i]  = $urandom_range(0, 1) != 0;
                t_rdy[i]  = $urandom_range(0, 3) != 0;
                t_data[i] = $urandom;
            end
            exe_is_br  = $urandom_range(0, 4) == 0;
            exe_is_jmp = $urandom_range(0, 9) == 0;
            exe_funct3 = 3'($urandom_range(0, 7));
            exe_a      = $urandom;
            exe_b      = ($urandom_range(0, 2) == 0) ? exe_a : $urandom;
            exe_target = $urandom;
            cycle();
        end

        idle_inputs();
        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
